// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its
// rotate-priority picker.
package uart_arb_pkg;

  localparam int LOCK_CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_RDY
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: returns the first set request found
// searching upward from ptr, wrapping modulo N.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  logic [IW:0]  sum;

  // rot[k] is the request sitting k places above ptr; scanning k downward
  // lets the nearest request win.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IW + 1)'(k);
        if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
        found = 1'b1;
        idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one non-FIFO UART transmitter among NUM_REQ
// byte sources, with optional per-packet grant lock and lock timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter bit  LOCK_EN      = 1'b1,
  parameter int  LOCK_TIMEOUT = 1023,
  localparam int GW           = clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [NUM_REQ-1:0]   in_last,
  input  logic [8*NUM_REQ-1:0] in_data,
  output logic [NUM_REQ-1:0]   in_ready,
  input  logic                 txrdy,
  output logic [7:0]           tx_hold_reg,
  output logic                 tx_load,
  output logic [GW-1:0]        grant_id,
  output logic                 locked,
  output logic                 busy
);

  arb_state_e            state, state_nxt;
  logic [GW-1:0]         ptr;
  logic [GW-1:0]         pick_idx;
  logic                  pick_found;
  logic [NUM_REQ-1:0]    gnt_mask;
  logic [NUM_REQ-1:0]    cand;
  logic [7:0]            gnt_data;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic                  lock_expired;
  logic [LOCK_CNT_W-1:0] lock_cnt;

  always_comb begin
    gnt_mask  = '0;
    gnt_data  = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        gnt_mask[i] = 1'b1;
        gnt_data    = in_data[8*i +: 8];
        gnt_valid   = in_valid[i];
        gnt_last    = in_last[i];
      end
    end
  end

  // While locked only the owner may be picked, so the pointer is irrelevant.
  assign cand         = locked ? (in_valid & gnt_mask) : in_valid;
  assign lock_expired = locked && !gnt_valid && (state == IDLE) &&
                        (lock_cnt == LOCK_CNT_W'(LOCK_TIMEOUT - 1));

  uart_rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (cand),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (txrdy && pick_found) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!txrdy) state_nxt = WAIT_RDY;
      WAIT_RDY:  if (txrdy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Strobe, byte and ready are all registered out of LOAD so the TX core
  // sees the hold register and its load strobe in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready    <= '0;
      tx_hold_reg <= '0;
      tx_load     <= 1'b0;
      grant_id    <= '0;
      locked      <= 1'b0;
      busy        <= 1'b0;
      ptr         <= '0;
      lock_cnt    <= '0;
    end else begin
      busy     <= (state_nxt != IDLE);
      in_ready <= '0;
      tx_load  <= 1'b0;
      if (state == IDLE && state_nxt == LOAD) grant_id <= pick_idx;
      if (state == LOAD) begin
        in_ready    <= gnt_mask;
        tx_load     <= 1'b1;
        tx_hold_reg <= gnt_data;
        ptr         <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
        locked      <= LOCK_EN && !gnt_last;
      end else if (lock_expired) begin
        locked <= 1'b0;
      end
      if (!locked || gnt_valid || lock_expired) lock_cnt <= '0;
      else if (state == IDLE)                  lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a UART TX core
// model driving txrdy, and a round-robin/lock reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [8*N-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           txrdy;
  logic [7:0]     tx_hold_reg;
  logic           tx_load;
  logic [1:0]     grant_id;
  logic           locked;
  logic           busy;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .LOCK_EN(1'b1),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_data(in_data),
    .in_ready(in_ready),
    .txrdy(txrdy),
    .tx_hold_reg(tx_hold_reg),
    .tx_load(tx_load),
    .grant_id(grant_id),
    .locked(locked),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int       n_checks;
  int       n_fail;
  bit [8:0] q [N][$];      // {last, data} per requester
  int       m_ptr;
  bit       m_locked;
  int       m_owner;
  int       tx_left;
  bit       bp;
  int       low_lo, low_hi;
  int       grant_log[$];
  bit       lock_log[$];
  int       cyc;
  int       last_accept_cyc;

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        in_valid[i]       = 1'b1;
        in_data[8*i +: 8] = q[i][0][7:0];
        in_last[i]        = q[i][0][8];
      end else begin
        in_valid[i]       = 1'b0;
        in_data[8*i +: 8] = 8'h00;
        in_last[i]        = 1'b0;
      end
    end
    txrdy = !bp && (tx_left == 0);
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_pick();
    if (m_locked) return (q[m_owner].size() > 0) ? m_owner : -1;
    for (int k = 0; k < N; k++) if (q[(m_ptr + k) % N].size() > 0) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    int idx, exp;
    bit [8:0] head;
    @(negedge clk);
    cyc++;
    n_checks++;
    if (!$onehot0(in_ready) || (tx_load !== (in_ready != '0))) begin
      n_fail++;
      $display("FAIL strobe_shape: in_ready=%b tx_load=%b, need at most one ready bit matching tx_load", in_ready, tx_load);
    end
    if (tx_load === 1'b1) begin
      n_checks++;
      if (txrdy !== 1'b1) begin
        n_fail++;
        $display("FAIL load_while_not_ready: tx_load=1 with txrdy=%b, need txrdy=1", txrdy);
      end
      tx_left = int'($urandom_range(low_hi, low_lo));
    end else if (tx_left > 0) begin
      tx_left--;
    end
    if ($onehot(in_ready)) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (in_ready[i]) idx = i;
      exp = model_pick();
      last_accept_cyc = cyc;
      grant_log.push_back(idx);
      n_checks++;
      if (exp < 0 || idx != exp || grant_id !== exp[1:0]) begin
        n_fail++;
        $display("FAIL grant: ready index %0d grant_id %0d, expected %0d", idx, grant_id, exp);
      end
      if (q[idx].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_ready: requester %0d got in_ready with nothing pending", idx);
      end else begin
        head = q[idx].pop_front();
        n_checks++;
        if (tx_hold_reg !== head[7:0]) begin
          n_fail++;
          $display("FAIL hold_data: tx_hold_reg=%h, expected %h", tx_hold_reg, head[7:0]);
        end
        n_checks++;
        if (locked !== !head[8]) begin
          n_fail++;
          $display("FAIL lock_after_byte: locked=%b, expected %b", locked, !head[8]);
        end
        lock_log.push_back(locked);
        m_ptr    = (idx + 1) % N;
        m_locked = !head[8];
        m_owner  = idx;
      end
    end
    drive();
  endtask

  task automatic drain(input int bound, input string name);
    int n;
    n = 0;
    while ((any_pending() || busy === 1'b1 || tx_left != 0) && n < bound) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL %s_timeout: still pending after %0d cycles, expected drain", name, n);
    end
  endtask

  task automatic wait_grants(input int cnt, input int bound, input string name);
    int n;
    n = 0;
    while (grant_log.size() < cnt && n < bound) begin
      step();
      n++;
    end
    n_checks++;
    if (grant_log.size() < cnt) begin
      n_fail++;
      $display("FAIL %s_no_grant: %0d grants after %0d cycles, expected %0d", name, grant_log.size(), n, cnt);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    m_ptr = 0; m_locked = 1'b0; m_owner = 0;
    tx_left = 0; bp = 1'b0; low_lo = 1; low_hi = 3;
    grant_log.delete(); lock_log.delete(); cyc = 0;
    drive();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    q[0].push_back({1'b1, 8'h3C});
    drive();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, tx_hold_reg, tx_load, grant_id, locked, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b hold=%h load=%b gid=%0d locked=%b busy=%b, expected all 0",
               in_ready, tx_hold_reg, tx_load, grant_id, locked, busy);
    end
  endtask

  task automatic test_single();
    int start;
    apply_reset();
    q[2].push_back({1'b1, 8'hA5});
    drive();
    start = cyc;
    wait_grants(1, 20, "single");
    n_checks++;
    if (last_accept_cyc - start != 2) begin
      n_fail++;
      $display("FAIL single_latency: accept %0d edges after request, expected 2", last_accept_cyc - start);
    end
    n_checks++;
    if (tx_hold_reg !== 8'hA5 || grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL single_result: hold=%h gid=%0d, expected a5 and 2", tx_hold_reg, grant_id);
    end
    drain(100, "single");
  endtask

  task automatic test_fairness();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    for (int i = 0; i < N; i++)
      repeat (2) q[i].push_back({1'b1, 8'($urandom)});
    drive();
    drain(500, "fair");
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (grant_log.size() <= k || grant_log[k] != exp_order[k]) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: got %0d, expected %0d", k,
                 (grant_log.size() > k) ? grant_log[k] : -1, exp_order[k]);
      end
    end
  endtask

  task automatic test_lock();
    int exp_g[4] = '{1, 1, 1, 3};
    bit exp_l[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    q[1].push_back({1'b0, 8'h11});
    q[1].push_back({1'b0, 8'h22});
    q[1].push_back({1'b1, 8'h33});
    q[3].push_back({1'b1, 8'h44});
    drive();
    drain(500, "lock");
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (grant_log.size() <= k || grant_log[k] != exp_g[k] || lock_log[k] != exp_l[k]) begin
        n_fail++;
        $display("FAIL lock_seq[%0d]: grant %0d locked %0d, expected grant %0d locked %0d", k,
                 (grant_log.size() > k) ? grant_log[k] : -1,
                 (lock_log.size() > k) ? int'(lock_log[k]) : -1, exp_g[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int idle_locked, n;
    apply_reset();
    q[0].push_back({1'b0, 8'h5A});
    q[2].push_back({1'b1, 8'hC3});
    drive();
    wait_grants(1, 30, "tmo");
    idle_locked = 0;
    n = 0;
    while (locked === 1'b1 && n < 300) begin
      step();
      n++;
      if (busy === 1'b0 && locked === 1'b1) idle_locked++;
    end
    n_checks++;
    if (locked !== 1'b0 || idle_locked != TO) begin
      n_fail++;
      $display("FAIL lock_timeout: locked=%b after %0d locked idle cycles, expected release after %0d",
               locked, idle_locked, TO);
    end
    n_checks++;
    if (grant_log.size() != 1) begin
      n_fail++;
      $display("FAIL lock_blocks_others: %0d grants while locked, expected 1", grant_log.size());
    end
    m_locked = 1'b0;
    drain(200, "tmo");
    n_checks++;
    if (grant_log.size() != 2 || grant_log[1] != 2) begin
      n_fail++;
      $display("FAIL tmo_next_grant: got %0d grants, last %0d, expected second grant to 2",
               grant_log.size(), grant_log[grant_log.size()-1]);
    end
  endtask

  task automatic test_backpressure();
    int bad, start;
    apply_reset();
    bp = 1'b1;
    q[1].push_back({1'b1, 8'($urandom)});
    q[2].push_back({1'b1, 8'($urandom)});
    drive();
    bad = 0;
    repeat (200) begin
      step();
      if (in_ready !== '0 || tx_load !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d cycles with a strobe while txrdy=0, expected 0", bad);
    end
    bp = 1'b0;
    drive();
    start = cyc;
    wait_grants(1, 20, "bp");
    n_checks++;
    if (last_accept_cyc - start != 2) begin
      n_fail++;
      $display("FAIL bp_latency: first accept %0d edges after txrdy rose, expected 2", last_accept_cyc - start);
    end
    drain(200, "bp");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    low_lo = 10; low_hi = 10;
    q[1].push_back({1'b0, 8'h71});
    q[3].push_back({1'b1, 8'h73});
    drive();
    wait_grants(1, 20, "rmid");
    step();
    n_checks++;
    if (busy !== 1'b1 || locked !== 1'b1 || txrdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_setup: busy=%b locked=%b txrdy=%b, expected 1 1 0", busy, locked, txrdy);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, tx_hold_reg, tx_load, grant_id, locked, busy} !== '0) begin
      n_fail++;
      $display("FAIL rmid_reset_values: ready=%b hold=%h load=%b gid=%0d locked=%b busy=%b, expected all 0",
               in_ready, tx_hold_reg, tx_load, grant_id, locked, busy);
    end
    m_ptr = 0; m_locked = 1'b0; m_owner = 0;
    grant_log.delete(); lock_log.delete();
    q[2].push_back({1'b1, 8'h72});
    low_lo = 1; low_hi = 3;
    step();
    step();
    reset_n = 1'b1;
    drain(300, "rmid");
    n_checks++;
    if (grant_log.size() != 2 || grant_log[0] != 2) begin
      n_fail++;
      $display("FAIL rmid_first_grant: %0d grants, first %0d, expected first grant to 2",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  task automatic test_random();
    int total, nb;
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      low_lo = 1; low_hi = 6;
      total = 0;
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(3, 0)) begin
          nb = int'($urandom_range(3, 1));
          for (int b = 0; b < nb; b++) q[i].push_back({(b == nb - 1), 8'($urandom)});
          total += nb;
        end
      end
      drive();
      drain(5000, "rand");
      n_checks++;
      if (grant_log.size() != total) begin
        n_fail++;
        $display("FAIL rand_count: %0d bytes sent, expected %0d", grant_log.size(), total);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bp = 1'b0; tx_left = 0; low_lo = 1; low_hi = 3;
    m_ptr = 0; m_locked = 1'b0; m_owner = 0; cyc = 0; last_accept_cyc = 0;
    drive();
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
